enemy_hit_detect: RTL and testbench
===================================

// Module: enemy_hit_detect
// PURPOSE
// Consumer of one enemy channel's position stream (xenemy/yenemy/spawn from that enemy's control unit).
// Resolves each enemy life: destroyed by the player's shot, or reached its target base.
// Emits a one-cycle kill request back to the enemy control unit, plus score/base-damage pulses.
// Drives an explosion marker for the vector renderer.
// PARAMETERS
// OUT_WIDTH      8     coordinate width; matches the enemy control unit
// HIT_RADIUS     4     max |dx| and |dy| (inclusive) counted as a hit
// X_BASE_LIMIT   16    enemy reaching x <= this value has struck the base
// EXPLODE_TICKS  8     number of frame_pulse ticks the explosion marker stays visible
// PORTS
// clk          in   1          system clock
// rst          in   1          synchronous active-high reset
// en           in   1          channel enable; low acts as soft reset
// frame_pulse  in   1          one-cycle tick; times the explosion
// spawn        in   1          enemy alive (level) from the enemy control unit
// xenemy       in   OUT_WIDTH  enemy x
// yenemy       in   OUT_WIDTH  enemy y
// fire         in   1          one-cycle player shot pulse
// xcross       in   OUT_WIDTH  crosshair x, sampled on fire
// ycross       in   OUT_WIDTH  crosshair y, sampled on fire
// kill         out  1          one-cycle despawn request to the enemy control unit
// score_pulse  out  1          one-cycle, enemy destroyed by player
// base_hit     out  1          one-cycle, enemy reached base
// explode      out  1          explosion marker visible
// xexplode     out  OUT_WIDTH  explosion x, latched enemy x at hit
// yexplode     out  OUT_WIDTH  explosion y, latched enemy y at hit
// BEHAVIOUR
// - All outputs registered. Reset or !en value: state IDLE, every output 0, tick counter 0, spawn_q 0.
// - spawn_q: spawn delayed by one cycle. Spawn rising edge = spawn & !spawn_q.
// - FSM states: IDLE, TRACK, EXPLODE, BASE.
// - IDLE: on a spawn rising edge, go to TRACK. A spawn level held high without a rising edge is ignored.
//   This stops re-tracking an enemy whose kill has not yet taken effect.
// - TRACK, checked in this priority order each cycle:
//   1 spawn=0: go to IDLE, no pulses.
//   2 fire=1 and hit: go to EXPLODE. Next cycle kill=1 and score_pulse=1.
//     Latch xexplode/yexplode from xenemy/yenemy as sampled on the fire cycle. Clear the tick counter.
//   3 xenemy <= X_BASE_LIMIT: go to BASE. Next cycle kill=1 and base_hit=1.
//   A hit and base arrival in the same cycle count as a hit only.
// - Hit test: |xenemy-xcross| <= HIT_RADIUS and |yenemy-ycross| <= HIT_RADIUS.
//   Differences computed at OUT_WIDTH+1 bits, unsigned magnitude, no wrap.
//   Example: 255 vs 0 is a distance of 255.
// - Latency: fire cycle N gives kill/score_pulse at cycle N+1.
// - EXPLODE: explode=1. Each frame_pulse increments the counter.
//   On the frame_pulse that makes the count EXPLODE_TICKS: go to IDLE; explode=0 from the next cycle.
//   xexplode/yexplode hold until the next hit.
// - BASE: lasts exactly one cycle, in which base_hit=kill=1. Then IDLE.
// - fire outside TRACK is ignored.
// - kill/score_pulse/base_hit never exceed one cycle per enemy life.
// - rst or en=0 in any state takes effect at the next edge and aborts an explosion immediately.
// TESTING
// - Reset: hold rst 2 cycles with random inputs -> all outputs 0, state IDLE.
// - Hit: spawn 0->1, x=100 y=50, fire with cross (102,48) -> next cycle kill=1, score_pulse=1, explode=1,
//   xexplode=100, yexplode=50; after 8 frame_pulses explode=0.
// - Radius edge: cross (104,50) with enemy (100,50) -> hit; cross (105,50) -> no pulse, remain TRACK.
//   Cross (0,0) with enemy (255,0) -> miss (no wrap).
// - Base: enemy x ramps down to 16 with no fire -> single-cycle kill=1 and base_hit=1, score_pulse=0, explode=0.
// - Simultaneous: xenemy=16 and fire with cross (16,y) -> score_pulse=1, base_hit=0.
// - Abort: en=0 at tick 3 of an explosion -> next cycle explode=0.
//   spawn held high afterwards with no new rising edge -> stays IDLE.

Source files
------------

// File: rtl/enemy_hit_detect.sv
// Resolves each enemy life on one channel: shot down by the player or reached the base.
// Issues a one-cycle kill back to the enemy control unit and drives the explosion marker.
module enemy_hit_detect #(
  parameter int OUT_WIDTH     = 8,
  parameter int HIT_RADIUS    = 4,
  parameter int X_BASE_LIMIT  = 16,
  parameter int EXPLODE_TICKS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 frame_pulse,
  input  logic                 spawn,
  input  logic [OUT_WIDTH-1:0] xenemy,
  input  logic [OUT_WIDTH-1:0] yenemy,
  input  logic                 fire,
  input  logic [OUT_WIDTH-1:0] xcross,
  input  logic [OUT_WIDTH-1:0] ycross,
  output logic                 kill,
  output logic                 score_pulse,
  output logic                 base_hit,
  output logic                 explode,
  output logic [OUT_WIDTH-1:0] xexplode,
  output logic [OUT_WIDTH-1:0] yexplode
);

  typedef enum logic [1:0] {IDLE, TRACK, EXPLODE, BASE} state_t;

  localparam int TW = $clog2(EXPLODE_TICKS + 1);
  localparam logic [OUT_WIDTH:0]   RADIUS     = (OUT_WIDTH + 1)'(HIT_RADIUS);
  localparam logic [OUT_WIDTH-1:0] BASE_LIMIT = OUT_WIDTH'(X_BASE_LIMIT);
  localparam logic [TW-1:0]        LAST_TICK  = TW'(EXPLODE_TICKS - 1);

  state_t             state;
  state_t             state_nxt;
  logic               spawn_q;
  logic [TW-1:0]      ticks;
  logic [OUT_WIDTH:0] dx;
  logic [OUT_WIDTH:0] dy;
  logic               hit;
  logic               at_base;
  logic               spawn_rise;
  logic               last_tick;
  logic               kill_d;
  logic               score_d;
  logic               base_d;
  logic               explode_d;

  // Distances are unsigned magnitudes one bit wider than the coordinates, so they never wrap.
  always_comb begin
    dx = (xenemy >= xcross) ? ({1'b0, xenemy} - {1'b0, xcross}) : ({1'b0, xcross} - {1'b0, xenemy});
    dy = (yenemy >= ycross) ? ({1'b0, yenemy} - {1'b0, ycross}) : ({1'b0, ycross} - {1'b0, yenemy});
    hit        = (dx <= RADIUS) && (dy <= RADIUS);
    at_base    = (xenemy <= BASE_LIMIT);
    spawn_rise = spawn && !spawn_q;
    last_tick  = frame_pulse && (ticks == LAST_TICK);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (spawn_rise) state_nxt = TRACK;
      TRACK: begin
        if (!spawn)              state_nxt = IDLE;
        else if (fire && hit)    state_nxt = EXPLODE;
        else if (at_base)        state_nxt = BASE;
      end
      EXPLODE: if (last_tick) state_nxt = IDLE;
      BASE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    score_d   = (state == TRACK) && (state_nxt == EXPLODE);
    base_d    = (state == TRACK) && (state_nxt == BASE);
    kill_d    = score_d || base_d;
    explode_d = (state_nxt == EXPLODE);
  end

  // Disabling the channel is a soft reset, so it also aborts a running explosion.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state       <= IDLE;
      spawn_q     <= 1'b0;
      ticks       <= '0;
      kill        <= 1'b0;
      score_pulse <= 1'b0;
      base_hit    <= 1'b0;
      explode     <= 1'b0;
      xexplode    <= '0;
      yexplode    <= '0;
    end else begin
      state       <= state_nxt;
      spawn_q     <= spawn;
      kill        <= kill_d;
      score_pulse <= score_d;
      base_hit    <= base_d;
      explode     <= explode_d;
      if (score_d) begin
        ticks    <= '0;
        xexplode <= xenemy;
        yexplode <= yenemy;
      end else if ((state == EXPLODE) && frame_pulse) begin
        ticks <= ticks + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_enemy_hit_detect.sv
// Randomised and directed bench for enemy_hit_detect; a monitor checks every kill
// against outcomes predicted from plain distance/position rules.
module tb_enemy_hit_detect;

  localparam int OUT_WIDTH     = 8;
  localparam int HIT_RADIUS    = 4;
  localparam int X_BASE_LIMIT  = 16;
  localparam int EXPLODE_TICKS = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 frame_pulse;
  logic                 spawn;
  logic [OUT_WIDTH-1:0] xenemy;
  logic [OUT_WIDTH-1:0] yenemy;
  logic                 fire;
  logic [OUT_WIDTH-1:0] xcross;
  logic [OUT_WIDTH-1:0] ycross;
  logic                 kill;
  logic                 score_pulse;
  logic                 base_hit;
  logic                 explode;
  logic [OUT_WIDTH-1:0] xexplode;
  logic [OUT_WIDTH-1:0] yexplode;

  typedef struct {
    int cyc;
    bit score;
    int x;
    int y;
    bit measure;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   model_alive = 1'b0;
  bit   model_prev_spawn = 1'b0;
  bit   auto_frame = 1'b1;
  bit   measure_next = 1'b1;
  bit   event_now = 1'b0;
  bit   done = 1'b0;

  enemy_hit_detect #(
    .OUT_WIDTH(OUT_WIDTH), .HIT_RADIUS(HIT_RADIUS),
    .X_BASE_LIMIT(X_BASE_LIMIT), .EXPLODE_TICKS(EXPLODE_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .frame_pulse(frame_pulse), .spawn(spawn),
    .xenemy(xenemy), .yenemy(yenemy), .fire(fire), .xcross(xcross), .ycross(ycross),
    .kill(kill), .score_pulse(score_pulse), .base_hit(base_hit), .explode(explode),
    .xexplode(xexplode), .yexplode(yexplode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    frame_pulse = auto_frame ? ($urandom_range(0, 2) == 0) : 1'b0;
  endtask

  // Drive one cycle of inputs and predict from game rules whether this cycle ends the life.
  task automatic applyStimulus(input bit sp, input int x, input int y,
                               input bit f, input int xc, input int yc);
    exp_t e;
    spawn  = sp;
    xenemy = 8'(x);
    yenemy = 8'(y);
    fire   = f;
    xcross = 8'(xc);
    ycross = 8'(yc);
    event_now = 1'b0;
    if (rst || !en) begin
      model_alive = 1'b0;
    end else if (model_alive) begin
      if (!sp) begin
        model_alive = 1'b0;
      end else if (f && absdiff(x, xc) <= HIT_RADIUS && absdiff(y, yc) <= HIT_RADIUS) begin
        e.cyc = cyc + 1; e.score = 1'b1; e.x = x; e.y = y; e.measure = measure_next;
        sbq.push_back(e);
        model_alive = 1'b0;
        event_now = 1'b1;
      end else if (x <= X_BASE_LIMIT) begin
        e.cyc = cyc + 1; e.score = 1'b0; e.x = x; e.y = y; e.measure = 1'b0;
        sbq.push_back(e);
        model_alive = 1'b0;
        event_now = 1'b1;
      end
    end else if (sp && !model_prev_spawn) begin
      model_alive = 1'b1;
    end
    model_prev_spawn = (rst || !en) ? 1'b0 : sp;
    step();
  endtask

  task automatic waitIdle();
    int n = 0;
    while (explode !== 1'b0 && n < 500) begin
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
      n++;
    end
    checkOutput("explode_settle", int'(explode), 0);
    repeat (2) applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  // Monitor: every kill must match the oldest predicted outcome, in the predicted cycle.
  initial begin
    exp_t e;
    int   n;
    int   bound;
    forever begin
      @(negedge clk);
      if (!done) begin
        if ((score_pulse === 1'b1 || base_hit === 1'b1) && kill !== 1'b1) begin
          checks++;
          failures++;
          $display("[TB] FAIL pulse_without_kill: score=%0b base=%0b kill=%0b required kill=1", score_pulse, base_hit, kill);
        end
        if (kill === 1'b1) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_kill: kill=1 at cycle %0d, required 0", cyc);
          end else begin
            e = sbq.pop_front();
            checkOutput("kill_cycle", cyc, e.cyc);
            checkOutput("score_pulse", int'(score_pulse), int'(e.score));
            checkOutput("base_hit", int'(base_hit), int'(!e.score));
            checkOutput("explode_at_kill", int'(explode), int'(e.score));
            if (e.score) begin
              checkOutput("xexplode", int'(xexplode), e.x);
              checkOutput("yexplode", int'(yexplode), e.y);
              if (e.measure) begin
                n = 0;
                bound = 0;
                while (explode === 1'b1 && bound < 2000) begin
                  if (frame_pulse) n++;
                  bound++;
                  @(negedge clk);
                end
                checkOutput("explode_ticks", n, EXPLODE_TICKS);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; frame_pulse = 1'b0; spawn = 1'b0; fire = 1'b0;
    xenemy = '0; yenemy = '0; xcross = '0; ycross = '0;

    // Reset held two cycles under random inputs.
    repeat (2) begin
      en = 1'($urandom);
      applyStimulus(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
    checkOutput("reset_kill", int'(kill), 0);
    checkOutput("reset_score", int'(score_pulse), 0);
    checkOutput("reset_base", int'(base_hit), 0);
    checkOutput("reset_explode", int'(explode), 0);
    checkOutput("reset_xexplode", int'(xexplode), 0);
    checkOutput("reset_yexplode", int'(yexplode), 0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);

    // Basic hit.
    applyStimulus(1'b1, 100, 50, 1'b0, 0, 0);
    applyStimulus(1'b1, 100, 50, 1'b1, 102, 48);
    checkOutput("hit_kill", int'(kill), 1);
    checkOutput("hit_score", int'(score_pulse), 1);
    checkOutput("hit_explode", int'(explode), 1);
    checkOutput("hit_xexplode", int'(xexplode), 100);
    checkOutput("hit_yexplode", int'(yexplode), 50);
    waitIdle();

    // Radius edges and no-wrap distance.
    applyStimulus(1'b1, 100, 50, 1'b0, 0, 0);
    applyStimulus(1'b1, 100, 50, 1'b1, 105, 50);
    checkOutput("radius5_kill", int'(kill), 0);
    applyStimulus(1'b1, 100, 50, 1'b1, 104, 50);
    checkOutput("radius4_score", int'(score_pulse), 1);
    waitIdle();
    applyStimulus(1'b1, 255, 0, 1'b0, 0, 0);
    applyStimulus(1'b1, 255, 0, 1'b1, 0, 0);
    checkOutput("nowrap_kill", int'(kill), 0);
    waitIdle();

    // Base arrival, then spawn held high must not re-track.
    applyStimulus(1'b1, 30, 60, 1'b0, 0, 0);
    for (int x = 29; x >= 16; x--) applyStimulus(1'b1, x, 60, 1'b0, 0, 0);
    checkOutput("base_kill", int'(kill), 1);
    checkOutput("base_hit", int'(base_hit), 1);
    checkOutput("base_score", int'(score_pulse), 0);
    checkOutput("base_explode", int'(explode), 0);
    applyStimulus(1'b1, 16, 60, 1'b1, 16, 60);
    checkOutput("base_single_kill", int'(kill), 0);
    applyStimulus(1'b1, 16, 60, 1'b1, 16, 60);
    checkOutput("held_spawn_kill", int'(kill), 0);
    waitIdle();

    // Hit and base arrival together count as a hit.
    applyStimulus(1'b1, 16, 80, 1'b0, 0, 0);
    applyStimulus(1'b1, 16, 80, 1'b1, 16, 80);
    checkOutput("simul_score", int'(score_pulse), 1);
    checkOutput("simul_base", int'(base_hit), 0);
    waitIdle();

    // Explosion aborted by en=0 after three ticks.
    auto_frame = 1'b0;
    measure_next = 1'b0;
    frame_pulse = 1'b0;
    applyStimulus(1'b1, 120, 120, 1'b0, 0, 0);
    applyStimulus(1'b1, 120, 120, 1'b1, 120, 120);
    measure_next = 1'b1;
    repeat (3) begin
      frame_pulse = 1'b1;
      applyStimulus(1'b1, 120, 120, 1'b0, 0, 0);
    end
    checkOutput("abort_explode_before", int'(explode), 1);
    en = 1'b0;
    applyStimulus(1'b1, 120, 120, 1'b0, 0, 0);
    checkOutput("abort_explode_after", int'(explode), 0);
    repeat (3) applyStimulus(1'b1, 120, 120, 1'b1, 120, 120);
    checkOutput("abort_stay_idle", int'(explode | kill), 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
    en = 1'b1;
    auto_frame = 1'b1;
    repeat (2) applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);

    // Random enemy lives.
    for (int life = 0; life < 30; life++) begin
      int x, y, xc, yc, n;
      bit f, sp;
      x = int'($urandom_range(40, 255));
      y = int'($urandom_range(0, 255));
      applyStimulus(1'b1, x, y, 1'b0, 0, 0);
      n = 0;
      while (model_alive && n < 400) begin
        x  = clamp8(x - int'($urandom_range(0, 3)));
        y  = clamp8(y + int'($urandom_range(0, 2)) - 1);
        f  = ($urandom_range(0, 3) == 0);
        xc = clamp8(x + int'($urandom_range(0, 12)) - 6);
        yc = clamp8(y + int'($urandom_range(0, 12)) - 6);
        sp = ($urandom_range(0, 80) != 0);
        applyStimulus(sp, x, y, f, xc, yc);
        n++;
      end
      if (event_now) begin
        repeat (2) applyStimulus(1'b1, x, y, 1'b1, x, y);
      end
      waitIdle();
    end

    repeat (5) applyStimulus(1'b0, 0, 0, 1'b0, 0, 0);
    checkOutput("scoreboard_empty", sbq.size(), 0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
